retire_trace_pipe: RTL and testbench

RETIRE_TRACE_PIPE -- requirements
Module: retire_trace_pipe

---
 rtl/retire_trace_pkg.sv | 39 +++
 rtl/retire_trace_stage.sv | 48 ++++
 rtl/retire_trace_pipe.sv | 156 +++++++++++++++
 tb/tb_retire_trace_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pkg.sv
// retire_trace_pkg: shared entry type, itype encoding and end-of-test defaults.
// Used by retire_trace_stage and retire_trace_pipe (macro RETIRE_TRACE_CNT_EN).
package retire_trace_pkg;

  localparam int TRACE_XLEN = 32;

  typedef logic [TRACE_XLEN-1:0] xword_t;

  // One-hot instruction type, bit order {j,i,r}
  localparam logic [2:0] ITYPE_R = 3'b001;
  localparam logic [2:0] ITYPE_I = 3'b010;
  localparam logic [2:0] ITYPE_J = 3'b100;

  localparam xword_t END_INSTR_DEF = 32'h0000000c;
  localparam xword_t END_VAL_DEF   = 32'h0000000a;

  typedef struct packed {
    logic       valid;
    xword_t     pc;
    xword_t     instr;
    logic [2:0] itype;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    xword_t     rd_val;
    xword_t     rs_val;
    xword_t     rt_val;
  } trace_entry_t;

  function automatic logic itype_legal(input logic [2:0] t);
    logic ok;
    case (t)
      ITYPE_R, ITYPE_I, ITYPE_J: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/retire_trace_stage.sv
// retire_trace_stage: one trace pipeline entry register.
// Supports hold (stall), kill (flush) and operand-value capture.
module retire_trace_stage
  import retire_trace_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  input  logic         kill_i,
  input  logic         cap_i,
  input  trace_entry_t entry_i,
  input  xword_t       rd_val_i,
  input  xword_t       rs_val_i,
  input  xword_t       rt_val_i,
  output trace_entry_t entry_o
);

  trace_entry_t entry_d;
  trace_entry_t entry_q;

  // Shift in unless held; capture values on entry; kill wins over hold.
  always_comb begin
    entry_d = entry_q;
    if (!hold_i) begin
      entry_d = entry_i;
      if (cap_i) begin
        entry_d.rd_val = rd_val_i;
        entry_d.rs_val = rs_val_i;
        entry_d.rt_val = rt_val_i;
      end
    end
    if (kill_i) begin
      entry_d.valid = 1'b0;
    end
  end

  // Entry register, cleared immediately on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/retire_trace_pipe.sv
// retire_trace_pipe: shadow pipeline tracing instructions to retirement.
// Build option: define RETIRE_TRACE_CNT_EN to include the retire counter.
module retire_trace_pipe
  import retire_trace_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CAP_STAGE    = 2,
  parameter int FLUSH_STAGES = 2,
  parameter int XLEN         = 32,
  parameter logic [XLEN-1:0] END_INSTR = XLEN'(END_INSTR_DEF),
  parameter logic [XLEN-1:0] END_VAL   = XLEN'(END_VAL_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic [2:0]      itype_in,
  input  logic [4:0]      rd_in,
  input  logic [4:0]      rs_in,
  input  logic [4:0]      rt_in,
  input  logic [XLEN-1:0] rd_val_in,
  input  logic [XLEN-1:0] rs_val_in,
  input  logic [XLEN-1:0] rt_val_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            wr_en_wb,
  input  logic [XLEN-1:0] wr_data_wb,
  input  logic [XLEN-1:0] end_reg_val,
  output logic            ret_valid,
  output logic [XLEN-1:0] ret_pc,
  output logic [XLEN-1:0] ret_instr,
  output logic [XLEN-1:0] ret_rd_val,
  output logic [XLEN-1:0] ret_rs_val,
  output logic [XLEN-1:0] ret_rt_val,
  output logic [2:0]      ret_itype,
  output logic [4:0]      ret_rd,
  output logic [4:0]      ret_rs,
  output logic [4:0]      ret_rt,
  output logic            ret_type_err,
  output logic            end_seen,
  output logic [31:0]     ret_count
);

  trace_entry_t fetch_entry;
  trace_entry_t stage_in [DEPTH];
  trace_entry_t stage_q  [DEPTH];
  trace_entry_t last;

  // Pack the fetch-side ports into a stage-0 entry.
  always_comb begin
    fetch_entry        = '0;
    fetch_entry.valid  = valid_in;
    fetch_entry.pc     = xword_t'(pc_in);
    fetch_entry.instr  = xword_t'(instr_in);
    fetch_entry.itype  = itype_in;
    fetch_entry.rd     = rd_in;
    fetch_entry.rs     = rs_in;
    fetch_entry.rt     = rt_in;
    fetch_entry.rd_val = xword_t'(rd_val_in);
    fetch_entry.rs_val = xword_t'(rs_val_in);
    fetch_entry.rt_val = xword_t'(rt_val_in);
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = fetch_entry;
    end else begin : g_body
      assign stage_in[k] = stage_q[k-1];
    end

    retire_trace_stage u_stage (
      .clk_i    (clk),
      .rst_i    (reset),
      .hold_i   (stall),
      .kill_i   (flush & (k < FLUSH_STAGES)),
      .cap_i    (k == CAP_STAGE),
      .entry_i  (stage_in[k]),
      .rd_val_i (xword_t'(rd_val_in)),
      .rs_val_i (xword_t'(rs_val_in)),
      .rt_val_i (xword_t'(rt_val_in)),
      .entry_o  (stage_q[k])
    );
  end

  assign last = stage_q[DEPTH-1];

  // Retire view of the oldest stage; writeback data overrides rd/rt.
  always_comb begin
    ret_valid    = last.valid & ~stall;
    ret_pc       = last.pc[XLEN-1:0];
    ret_instr    = last.instr[XLEN-1:0];
    ret_itype    = last.itype;
    ret_rd       = last.rd;
    ret_rs       = last.rs;
    ret_rt       = last.rt;
    ret_rs_val   = last.rs_val[XLEN-1:0];
    ret_rd_val   = last.rd_val[XLEN-1:0];
    ret_rt_val   = last.rt_val[XLEN-1:0];
    if (wr_en_wb) begin
      ret_rd_val = wr_data_wb;
      ret_rt_val = wr_data_wb;
    end
    ret_type_err = ret_valid & ~itype_legal(last.itype);
  end

  logic end_d;
  logic end_q;

  // Sticky end-of-test detect on a retiring end marker.
  always_comb begin
    end_d = end_q;
    if (ret_valid && ret_instr == END_INSTR &&
        end_reg_val == END_VAL) begin
      end_d = 1'b1;
    end
  end

  // End-of-test flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_q <= 1'b0;
    end else begin
      end_q <= end_d;
    end
  end

  assign end_seen = end_q;

`ifdef RETIRE_TRACE_CNT_EN
  logic [31:0] cnt_d;
  logic [31:0] cnt_q;

  // Count every retire pulse, wrapping at 32 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (ret_valid) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ret_count = cnt_q;
`else
  assign ret_count = 32'd0;
`endif

endmodule

// File: tb/tb_retire_trace_pipe.sv
// tb_retire_trace_pipe: vector table, corner sequences and random run
// against a queue-based model of in-flight instructions.
module tb_retire_trace_pipe;

  localparam int DEPTH = 4;
  localparam int CAP   = 2;
  localparam int FL    = 2;
  localparam logic [31:0] ENDI = 32'h0000000c;
  localparam logic [31:0] ENDV = 32'h0000000a;
`ifdef RETIRE_TRACE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk, reset, valid_in, stall, flush, wr_en_wb;
  logic [31:0] pc_in, instr_in, rd_val_in, rs_val_in, rt_val_in;
  logic [31:0] wr_data_wb, end_reg_val;
  logic [2:0]  itype_in;
  logic [4:0]  rd_in, rs_in, rt_in;
  logic        ret_valid, ret_type_err, end_seen;
  logic [31:0] ret_pc, ret_instr, ret_rd_val, ret_rs_val, ret_rt_val;
  logic [31:0] ret_count;
  logic [2:0]  ret_itype;
  logic [4:0]  ret_rd, ret_rs, ret_rt;

  retire_trace_pipe dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .pc_in(pc_in), .instr_in(instr_in), .itype_in(itype_in),
    .rd_in(rd_in), .rs_in(rs_in), .rt_in(rt_in),
    .rd_val_in(rd_val_in), .rs_val_in(rs_val_in),
    .rt_val_in(rt_val_in), .stall(stall), .flush(flush),
    .wr_en_wb(wr_en_wb), .wr_data_wb(wr_data_wb),
    .end_reg_val(end_reg_val), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd_val(ret_rd_val), .ret_rs_val(ret_rs_val),
    .ret_rt_val(ret_rt_val), .ret_itype(ret_itype),
    .ret_rd(ret_rd), .ret_rs(ret_rs), .ret_rt(ret_rt),
    .ret_type_err(ret_type_err), .end_seen(end_seen),
    .ret_count(ret_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_ret = 0;
  logic [31:0] seen_pc [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: in-flight instructions, oldest first, with their age.
  typedef struct {
    logic [31:0] pc, instr;
    logic [2:0]  it;
    logic [4:0]  rd, rs, rt;
    logic [31:0] rdv, rsv, rtv;
    int          pos;
  } m_t;

  m_t          q [$];
  logic [31:0] m_cnt = 0;
  logic        m_end = 0;

  function automatic logic [31:0] exp_cnt();
    return CNT_EN ? m_cnt : 32'd0;
  endfunction

  task automatic model_edge();
    bit hv;
    m_t e;
    m_t keep [$];
    if (reset) begin
      q.delete(); m_cnt = 0; m_end = 0;
      return;
    end
    hv = (q.size() > 0) && (q[0].pos == DEPTH-1) && !stall;
    if (hv) begin
      m_cnt = m_cnt + 1;
      if (q[0].instr == ENDI && end_reg_val == ENDV) m_end = 1'b1;
    end
    if (!stall) begin
      if (hv) void'(q.pop_front());
      foreach (q[i]) begin
        e = q[i];
        e.pos = e.pos + 1;
        if (e.pos == CAP) begin
          e.rdv = rd_val_in; e.rsv = rs_val_in; e.rtv = rt_val_in;
        end
        q[i] = e;
      end
      if (valid_in) begin
        e.pc = pc_in; e.instr = instr_in; e.it = itype_in;
        e.rd = rd_in; e.rs = rs_in; e.rt = rt_in;
        e.rdv = rd_val_in; e.rsv = rs_val_in; e.rtv = rt_val_in;
        e.pos = 0;
        q.push_back(e);
      end
    end
    if (flush) begin
      foreach (q[i]) if (q[i].pos >= FL) keep.push_back(q[i]);
      q = keep;
    end
  endtask

  // Check outputs for the current cycle, then advance one clock.
  task automatic cycle();
    bit hv;
    m_t h;
    #1;
    if (reset) begin
      q.delete(); m_cnt = 0; m_end = 0;
    end
    hv = (q.size() > 0) && (q[0].pos == DEPTH-1);
    if (hv) h = q[0];
    chk("ret_valid", ret_valid, hv && !stall);
    if (ret_valid === 1'b1) begin
      n_ret++;
      seen_pc.push_back(ret_pc);
    end
    if (hv && !stall) begin
      chk("ret_pc", ret_pc, h.pc);
      chk("ret_instr", ret_instr, h.instr);
      chk("ret_itype", ret_itype, h.it);
      chk("ret_rd", ret_rd, h.rd);
      chk("ret_rs", ret_rs, h.rs);
      chk("ret_rt", ret_rt, h.rt);
      chk("ret_rs_val", ret_rs_val, h.rsv);
      chk("ret_rd_val", ret_rd_val, wr_en_wb ? wr_data_wb : h.rdv);
      chk("ret_rt_val", ret_rt_val, wr_en_wb ? wr_data_wb : h.rtv);
      chk("type_err", ret_type_err, $countones(h.it) != 1);
    end else begin
      chk("type_err_idle", ret_type_err, 0);
    end
    chk("end_seen", end_seen, m_end);
    chk("ret_count", ret_count, exp_cnt());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] pc, instr;
    logic [2:0]  it;
    logic [4:0]  rd;
    logic [31:0] rdv, rsv, rtv;
    logic        we;
    logic [31:0] wd;
    logic [31:0] e_rd, e_rs, e_rt;
    logic        e_err;
  } vec_t;

  task automatic set_vals(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
    rd_val_in = a; rs_val_in = b; rt_val_in = c;
  endtask

  // Load one instruction and run until it sits in the last stage.
  task automatic bring(input vec_t v);
    valid_in = 1'b1; pc_in = v.pc; instr_in = v.instr;
    itype_in = v.it; rd_in = v.rd;
    rs_in = v.rd + 5'd1; rt_in = v.rd + 5'd2;
    set_vals(~v.rdv, ~v.rsv, ~v.rtv);
    cycle();
    valid_in = 1'b0; pc_in = 32'hbad0; instr_in = 32'h0;
    for (int i = 0; i < DEPTH-1; i++) begin
      if (i == CAP-1) set_vals(v.rdv, v.rsv, v.rtv);
      else set_vals(32'hdead0000 + i, 32'hbeef0000 + i, 32'hcafe0000);
      cycle();
    end
    set_vals(32'h0bad0bad, 32'h0bad0bad, 32'h0bad0bad);
  endtask

  task automatic load4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; pc_in = base + 4 * i; instr_in = 32'h33 + i;
      itype_in = 3'b001; rd_in = 5'(i);
      cycle();
    end
    valid_in = 1'b0;
  endtask

  vec_t vt [6];
  vec_t v;
  int   base;

  initial begin
    vt[0] = '{32'h100, 32'h13, 3'b001, 5'd1, 32'h11, 32'h22, 32'h33,
              1'b0, 32'h0, 32'h11, 32'h22, 32'h33, 1'b0};
    vt[1] = '{32'h104, 32'h23, 3'b010, 5'd4, 32'h44, 32'h45, 32'h46,
              1'b1, 32'h55, 32'h55, 32'h45, 32'h55, 1'b0};
    vt[2] = '{32'h108, 32'h33, 3'b011, 5'd7, 32'h70, 32'h71, 32'h72,
              1'b0, 32'h0, 32'h70, 32'h71, 32'h72, 1'b1};
    vt[3] = '{32'h10c, 32'h6f, 3'b100, 5'd9, 32'hffffffff, 32'h0,
              32'h80000000, 1'b0, 32'h0, 32'hffffffff, 32'h0,
              32'h80000000, 1'b0};
    vt[4] = '{32'h110, 32'h67, 3'b000, 5'd31, 32'h1, 32'h2, 32'h3,
              1'b1, 32'h0, 32'h0, 32'h2, 32'h0, 1'b1};
    vt[5] = '{32'h114, 32'h73, 3'b111, 5'd0, 32'h5, 32'h6, 32'h7,
              1'b1, 32'hffffffff, 32'hffffffff, 32'h6, 32'hffffffff,
              1'b1};

    reset = 1'b1; valid_in = 0; stall = 0; flush = 0; wr_en_wb = 0;
    pc_in = 0; instr_in = 0; itype_in = 0; rd_in = 0; rs_in = 0;
    rt_in = 0; rd_val_in = 0; rs_val_in = 0; rt_val_in = 0;
    wr_data_wb = 0; end_reg_val = 0;
    @(negedge clk);
    #1;
    chk("rst_pc", ret_pc, 0);
    chk("rst_instr", ret_instr, 0);
    chk("rst_rd_val", ret_rd_val, 0);
    chk("rst_itype", ret_itype, 0);
    chk("rst_count", ret_count, 0);
    cycle();
    reset = 1'b0;
    cycle();

    // Vector table: single instruction through the pipe
    for (int r = 0; r < 6; r++) begin
      bring(vt[r]);
      wr_en_wb = vt[r].we; wr_data_wb = vt[r].wd;
      #1;
      chk("tbl_valid", ret_valid, 1);
      chk("tbl_pc", ret_pc, vt[r].pc);
      chk("tbl_rd_val", ret_rd_val, vt[r].e_rd);
      chk("tbl_rs_val", ret_rs_val, vt[r].e_rs);
      chk("tbl_rt_val", ret_rt_val, vt[r].e_rt);
      chk("tbl_type_err", ret_type_err, vt[r].e_err);
      cycle();
      wr_en_wb = 1'b0;
      if (r == 0) chk("first_count", ret_count, CNT_EN ? 1 : 0);
    end

    // Stall while the entry waits in the last stage
    v = vt[0]; v.pc = 32'h180;
    bring(v);
    stall = 1'b1;
    base = n_ret;
    repeat (3) cycle();
    chk("stall_quiet", n_ret - base, 0);
    stall = 1'b0;
    repeat (3) cycle();
    chk("stall_pulses", n_ret - base, 1);

    // Flush (while stalled) kills the two youngest of four
    seen_pc.delete();
    base = n_ret;
    load4(32'h200);
    stall = 1'b1; flush = 1'b1; valid_in = 1'b1; pc_in = 32'h2ff;
    cycle();
    stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    repeat (6) cycle();
    chk("flush_count", n_ret - base, 2);
    chk("flush_pc0", seen_pc[0], 32'h200);
    chk("flush_pc1", seen_pc[1], 32'h204);

    // End-of-test detection
    v = vt[0]; v.instr = ENDI;
    bring(v);
    end_reg_val = 32'h9;
    cycle();
    end_reg_val = 32'h0;
    repeat (2) cycle();
    chk("end_wrong_val", end_seen, 0);
    bring(v);
    end_reg_val = ENDV;
    cycle();
    end_reg_val = 32'h0;
    chk("end_set", end_seen, 1);
    repeat (3) cycle();
    chk("end_sticky", end_seen, 1);

    // Reset mid-stream with four valid entries
    load4(32'h300);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    base = n_ret;
    repeat (6) cycle();
    chk("rst_no_retire", n_ret - base, 0);
    chk("rst_mid_count", ret_count, 0);
    chk("rst_mid_end", end_seen, 0);
    v = vt[1]; v.pc = 32'h400;
    bring(v);
    #1;
    chk("post_rst_latency", ret_valid, 1);
    cycle();

`ifdef RETIRE_TRACE_CNT_EN
    // Counter wrap from all-ones to zero
    force dut.cnt_q = 32'hffffffff;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hffffffff;
    bring(vt[0]);
    cycle();
    chk("count_wrap", ret_count, 0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      valid_in = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 99) < 8);
      wr_en_wb = ($urandom_range(0, 9) < 3);
      pc_in = $urandom; wr_data_wb = $urandom;
      instr_in = ($urandom_range(0, 7) == 0) ? ENDI : $urandom;
      end_reg_val = ($urandom_range(0, 1) == 0) ? ENDV : $urandom;
      itype_in = 3'($urandom);
      rd_in = 5'($urandom); rs_in = 5'($urandom); rt_in = 5'($urandom);
      set_vals($urandom, $urandom, $urandom);
      cycle();
    end
    reset = 0; valid_in = 0; stall = 0; flush = 0; wr_en_wb = 0;
    repeat (DEPTH + 2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
